// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out bus of the byte-to-word packer.
// The master modport belongs to the producer/consumer pair, and the slave modport
// belongs to the packer itself.
interface byte_word_packer_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [7:0]    in_byte;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic [2:0]    out_nbytes;
    logic [LW-1:0] level;
    logic          overflow;

    modport master (
        output in_valid, in_byte, flush, out_ready,
        input  out_valid, out_word, out_nbytes, level, overflow
    );

    modport slave (
        input  in_valid, in_byte, flush, out_ready,
        output out_valid, out_word, out_nbytes, level, overflow
    );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit little-endian words and queues them in a small FIFO.
// The upstream side cannot be stalled. A word that completes while the FIFO is full
// and nothing drains is dropped, and the sticky overflow flag is raised.
module byte_word_packer #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    byte_word_packer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [1:0]    byte_cnt_reg;
    logic [31:0]   acc_reg;
    logic [31:0]   acc_merged;
    logic [31:0]   mem_word   [DEPTH];
    logic [2:0]    mem_nbytes [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          overflow_reg;

    logic [2:0]    eff_cnt;
    logic          push;
    logic          pop;
    logic          accept;

    // Each lane takes the incoming byte when it is the lane being filled.
    // This lets a word be pushed in the same cycle as its last byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign acc_merged[8*gi +: 8] =
                (bus.in_valid && (byte_cnt_reg == 2'(gi))) ? bus.in_byte : acc_reg[8*gi +: 8];
        end
    endgenerate

    // Push and pop decisions. A full FIFO still accepts a word if the head leaves this cycle.
    always_comb begin
        eff_cnt = {1'b0, byte_cnt_reg} + {2'b00, bus.in_valid};
        push    = (eff_cnt == 3'd4) || (bus.flush && (eff_cnt != 3'd0));
        pop     = (level_reg != '0) && bus.out_ready;
        accept  = push && ((level_reg < LW'(DEPTH)) || pop);
    end

    // Accumulator: clears on every push, including a push whose word is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_reg <= 2'd0;
            acc_reg      <= 32'd0;
        end else if (push) begin
            byte_cnt_reg <= 2'd0;
            acc_reg      <= 32'd0;
        end else if (bus.in_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            acc_reg      <= acc_merged;
        end
    end

    // FIFO storage is not reset. The empty flag gates whatever it holds.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_word[wr_ptr_reg]   <= acc_merged;
            mem_nbytes[wr_ptr_reg] <= eff_cnt;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({accept, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (push && !accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = (level_reg != '0);
    assign bus.out_word   = bus.out_valid ? mem_word[rd_ptr_reg]   : 32'd0;
    assign bus.out_nbytes = bus.out_valid ? mem_nbytes[rd_ptr_reg] : 3'd0;
    assign bus.level      = level_reg;
    assign bus.overflow   = overflow_reg;
endmodule
